// File: rtl/reset_seq_ctrl_if.sv
// rtl/reset_seq_ctrl_if.sv - lock/request inputs and staged reset outputs of reset_seq_ctrl
interface reset_seq_ctrl_if #(
  parameter int NUM_STAGES = 3
);
  logic                  locked;
  logic                  soft_reset_req;
  logic                  dcm_reset;
  logic [NUM_STAGES-1:0] stage_reset_n;
  logic                  ready;
  logic [3:0]            retry_cnt;

  // master: the sequencer; slave: the DCM/board side and reset consumers
  modport master (
    input  locked, soft_reset_req,
    output dcm_reset, stage_reset_n, ready, retry_cnt
  );
  modport slave (
    output locked, soft_reset_req,
    input  dcm_reset, stage_reset_n, ready, retry_cnt
  );
endinterface

// File: rtl/reset_seq_ctrl.sv
// rtl/reset_seq_ctrl.sv - DCM reset, lock qualification and staged per-domain reset release
module reset_seq_ctrl #(
  parameter int NUM_STAGES     = 3,
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int STABLE_CYCLES  = 16,
  parameter int STAGE_GAP      = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  reset_seq_ctrl_if.master rs
);

  typedef enum logic [2:0] {
    S_DCM_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first qualified cycle.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dcm_reset_q, dcm_reset_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [NUM_STAGES-1:0] stage_first, stage_next;
  logic                  ready_q, ready_d;
  logic [3:0]            retry_q, retry_d;
  logic [1:0]            lock_sync;
  logic                  locked_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[0], rs.locked};
    end
  end

  assign locked_s = lock_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_DCM_RST;
      cnt_q       <= '0;
      dcm_reset_q <= 1'b1;
      stage_q     <= '0;
      ready_q     <= 1'b0;
      retry_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcm_reset_q <= dcm_reset_d;
      stage_q     <= stage_d;
      ready_q     <= ready_d;
      retry_q     <= retry_d;
    end
  end

  // Stages come up in index order: shift a one in from bit 0.
  always_comb begin
    stage_first    = '0;
    stage_first[0] = 1'b1;
    stage_next     = '0;
    stage_next[0]  = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) begin
      stage_next[i] = stage_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    stage_d = stage_q;
    ready_d = ready_q;
    retry_d = retry_q;

    unique case (state_q)
      S_DCM_RST: begin
        if (cnt_q == DCM_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_DCM_RST;
          cnt_d   = '0;
          if (retry_q != 4'hf) begin
            retry_d = retry_q + 4'd1;
          end
        end
      end

      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          stage_d = stage_first;
          if (NUM_STAGES == 1) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_RELEASE: begin
        if (!locked_s) begin
          state_d = S_DCM_RST;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          stage_d = stage_next;
          if (stage_next[NUM_STAGES-1]) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        cnt_d = '0;
        // Lock loss takes priority over a software request.
        if (!locked_s) begin
          state_d = S_DCM_RST;
          stage_d = '0;
          ready_d = 1'b0;
        end else if (rs.soft_reset_req) begin
          state_d = S_STABLE;
          stage_d = '0;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = S_DCM_RST;
        cnt_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase

    dcm_reset_d = (state_d == S_DCM_RST);
  end

  assign rs.dcm_reset     = dcm_reset_q;
  assign rs.stage_reset_n = stage_q;
  assign rs.ready         = ready_q;
  assign rs.retry_cnt     = retry_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// tb/tb_reset_seq_ctrl.sv - bench for reset_seq_ctrl against a time-stamped phase model
module tb_reset_seq_ctrl;

  localparam int NUM_STAGES     = 3;
  localparam int DCM_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int STABLE_CYCLES  = 16;
  localparam int STAGE_GAP      = 8;

  localparam int P_DCM  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reset_seq_ctrl_if #(.NUM_STAGES(NUM_STAGES)) rs_if ();

  reset_seq_ctrl #(
    .NUM_STAGES    (NUM_STAGES),
    .DCM_RST_CYCLES(DCM_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .STAGE_GAP     (STAGE_GAP),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rs   (rs_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   cmp_en   = 1'b0;

  int   m_phase  = P_DCM;
  int   m_t0     = 0;
  int   m_n      = 0;
  int   m_rel_t0 = 0;
  int   m_retry  = 0;
  logic m_s1     = 1'b0;
  logic m_s2     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) cyc = 0;
    else        cyc = cyc + 1;
  end

  // Phase model: each phase remembers the edge it was entered on; outputs follow from elapsed time.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_phase = P_DCM; m_t0 = 0; m_n = 0; m_rel_t0 = 0; m_retry = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_n = m_n + 1;
      case (m_phase)
        P_DCM: if (m_n - m_t0 == DCM_RST_CYCLES) begin m_phase = P_WAIT; m_t0 = m_n; end
        P_WAIT: begin
          if (m_s2) begin
            m_phase = P_STAB; m_t0 = m_n;
          end else if (m_n - m_t0 == LOCK_TIMEOUT) begin
            m_phase = P_DCM; m_t0 = m_n;
            if (m_retry < 15) m_retry = m_retry + 1;
          end
        end
        P_STAB: begin
          if (!m_s2) begin
            m_phase = P_WAIT; m_t0 = m_n;
          end else if (m_n - m_t0 + 1 == STABLE_CYCLES) begin
            m_phase = (NUM_STAGES == 1) ? P_RUN : P_REL; m_rel_t0 = m_n;
          end
        end
        P_REL: begin
          if (!m_s2) begin
            m_phase = P_DCM; m_t0 = m_n;
          end else if (m_n - m_rel_t0 == (NUM_STAGES - 1) * STAGE_GAP) begin
            m_phase = P_RUN;
          end
        end
        default: begin
          if (!m_s2) begin
            m_phase = P_DCM; m_t0 = m_n;
          end else if (rs_if.soft_reset_req) begin
            m_phase = P_STAB; m_t0 = m_n;
          end
        end
      endcase
      m_s2 = m_s1;
      m_s1 = rs_if.locked;
    end
  end

  initial forever begin
    int exp_stage;
    @(negedge clk);
    if (cmp_en) begin
      exp_stage = 0;
      if (m_phase == P_REL || m_phase == P_RUN) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (m_n - m_rel_t0 >= k * STAGE_GAP) exp_stage = exp_stage | (1 << k);
        end
      end
      check("model_dcm_reset", int'(rs_if.dcm_reset), (m_phase == P_DCM) ? 1 : 0);
      check("model_stage_reset_n", int'(rs_if.stage_reset_n), exp_stage);
      check("model_ready", int'(rs_if.ready), (m_phase == P_RUN) ? 1 : 0);
      check("model_retry_cnt", int'(rs_if.retry_cnt), m_retry);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    rs_if.locked = 1'b0;
    rs_if.soft_reset_req = 1'b0;
    @(negedge clk);
    check("rst_dcm_reset", int'(rs_if.dcm_reset), 1);
    check("rst_stage_reset_n", int'(rs_if.stage_reset_n), 0);
    check("rst_ready", int'(rs_if.ready), 0);
    check("rst_retry_cnt", int'(rs_if.retry_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic at_cycle(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      n_checks++;
      n_fail++;
      $display("FAIL at_cycle: reached %0d expected %0d", cyc, k);
    end
  endtask

  initial begin
    int g;
    int hold;
    rs_if.locked = 1'b0;
    rs_if.soft_reset_req = 1'b0;
    apply_reset();
    cmp_en = 1'b1;

    // Nominal bring-up, then lock loss in RUN, then soft resets.
    at_cycle(3);   check("nom_dcm_c3", int'(rs_if.dcm_reset), 1);
    at_cycle(4);   check("nom_dcm_c4", int'(rs_if.dcm_reset), 0);
    at_cycle(10);  rs_if.locked = 1'b1;
    at_cycle(27);  check("nom_stage_c27", int'(rs_if.stage_reset_n), 0);
    at_cycle(28);  check("nom_stage_c28", int'(rs_if.stage_reset_n), 1);
    at_cycle(35);  check("nom_stage_c35", int'(rs_if.stage_reset_n), 1);
    at_cycle(36);  check("nom_stage_c36", int'(rs_if.stage_reset_n), 3);
    at_cycle(43);  check("nom_ready_c43", int'(rs_if.ready), 0);
    at_cycle(44);  check("nom_stage_c44", int'(rs_if.stage_reset_n), 7);
                   check("nom_ready_c44", int'(rs_if.ready), 1);
                   check("nom_retry", int'(rs_if.retry_cnt), 0);
    at_cycle(50);  rs_if.locked = 1'b0;
    at_cycle(52);  check("loss_ready_c52", int'(rs_if.ready), 1);
    at_cycle(53);  check("loss_stage_c53", int'(rs_if.stage_reset_n), 0);
                   check("loss_ready_c53", int'(rs_if.ready), 0);
                   check("loss_dcm_c53", int'(rs_if.dcm_reset), 1);
    at_cycle(56);  check("loss_dcm_c56", int'(rs_if.dcm_reset), 1);
    at_cycle(57);  check("loss_dcm_c57", int'(rs_if.dcm_reset), 0);
    at_cycle(60);  rs_if.locked = 1'b1;
    at_cycle(77);  check("loss_stage_c77", int'(rs_if.stage_reset_n), 0);
    at_cycle(78);  check("loss_stage_c78", int'(rs_if.stage_reset_n), 1);
    at_cycle(94);  check("loss_ready_c94", int'(rs_if.ready), 1);
    at_cycle(100); rs_if.soft_reset_req = 1'b1;
    at_cycle(101); rs_if.soft_reset_req = 1'b0;
                   check("soft_stage_c101", int'(rs_if.stage_reset_n), 0);
                   check("soft_ready_c101", int'(rs_if.ready), 0);
                   check("soft_dcm_c101", int'(rs_if.dcm_reset), 0);
    at_cycle(115); check("soft_stage_c115", int'(rs_if.stage_reset_n), 0);
    at_cycle(116); check("soft_stage_c116", int'(rs_if.stage_reset_n), 1);
    at_cycle(124); check("soft_stage_c124", int'(rs_if.stage_reset_n), 3);
    at_cycle(132); check("soft_ready_c132", int'(rs_if.ready), 1);
    at_cycle(140); rs_if.locked = 1'b0;
    at_cycle(142); rs_if.soft_reset_req = 1'b1;
    at_cycle(143); rs_if.soft_reset_req = 1'b0;
                   check("both_dcm_c143", int'(rs_if.dcm_reset), 1);
                   check("both_stage_c143", int'(rs_if.stage_reset_n), 0);

    // Lock glitch during qualification.
    apply_reset();
    at_cycle(10);  rs_if.locked = 1'b1;
    at_cycle(13);  rs_if.locked = 1'b0;
    at_cycle(14);  rs_if.locked = 1'b1;
    at_cycle(16);  check("glitch_dcm_c16", int'(rs_if.dcm_reset), 0);
    at_cycle(31);  check("glitch_stage_c31", int'(rs_if.stage_reset_n), 0);
                   check("glitch_dcm_c31", int'(rs_if.dcm_reset), 0);
    at_cycle(32);  check("glitch_stage_c32", int'(rs_if.stage_reset_n), 1);

    // Lock timeouts and retry saturation.
    apply_reset();
    at_cycle(35);  check("to_retry_c35", int'(rs_if.retry_cnt), 0);
    at_cycle(36);  check("to_retry_c36", int'(rs_if.retry_cnt), 1);
                   check("to_dcm_c36", int'(rs_if.dcm_reset), 1);
    at_cycle(72);  check("to_retry_c72", int'(rs_if.retry_cnt), 2);
    at_cycle(540); check("to_retry_c540", int'(rs_if.retry_cnt), 15);
    at_cycle(600); check("to_retry_c600", int'(rs_if.retry_cnt), 15);
    rs_if.locked = 1'b1;
    g = 0;
    while (!rs_if.ready && g < 300) begin @(negedge clk); g++; end
    check("to_ready", int'(rs_if.ready), 1);
    check("to_retry_after", int'(rs_if.retry_cnt), 15);

    // Async reset while stages are partly released.
    rs_if.locked = 1'b0;
    repeat (8) @(negedge clk);
    rs_if.locked = 1'b1;
    g = 0;
    while (!(rs_if.stage_reset_n[0] && !rs_if.ready) && g < 300) begin @(negedge clk); g++; end
    check("ar_in_release", int'(rs_if.stage_reset_n), 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_dcm", int'(rs_if.dcm_reset), 1);
    check("ar_stage", int'(rs_if.stage_reset_n), 0);
    check("ar_ready", int'(rs_if.ready), 0);
    check("ar_retry", int'(rs_if.retry_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Random lock behaviour and soft requests against the model.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rs_if.soft_reset_req = ($urandom_range(0, 19) == 0);
      if (hold == 0) begin
        rs_if.locked = ($urandom_range(0, 3) != 0);
        hold = rs_if.locked ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 45));
      end else begin
        hold--;
      end
      if (i == 2000) reset = 1'b0;
      if (i == 2003) reset = 1'b1;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
